// File: rtl/doa_frame_avg.sv
// doa_frame_avg: frame averager placed behind the vectoring-mode CORDIC.
// Aligns the sample strobe with the CORDIC outputs, accumulates 2^LOG2N
// accepted samples and reports peak magnitude, mean magnitude and a
// wrap-safe circular mean angle once per frame.
// Optional feature macro: DOA_FRAME_AVG_THRESH_EN (minimum-magnitude gate).
module doa_frame_avg #(
    parameter int LATENCY = 12,
    parameter int LOG2N   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic        frame_sync,
    input  logic [15:0] mag,
    input  logic [15:0] ang,
    input  logic [15:0] thresh,
    output logic        out_valid,
    output logic [15:0] mag_peak,
    output logic [15:0] mag_mean,
    output logic [15:0] ang_mean
);

    localparam int SW = 16 + LOG2N;
    localparam int CW = LOG2N + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'((1 << LOG2N) - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [LATENCY-1:0] vdly;
    logic               v_al;
    logic [15:0]        mag_c;
    logic               accept;

    // The angle sum holds a two's-complement value; its top 16 bits are the
    // arithmetic right shift by LOG2N, truncated to 16 bits.
    logic [15:0]        ref_ang;
    logic [SW-1:0]      ang_sum;
    logic [SW-1:0]      mag_sum;
    logic [15:0]        peak;
    logic [CW-1:0]      count;

    logic [15:0]        diff;
    logic [SW-1:0]      ang_sum_nx;
    logic [SW-1:0]      mag_sum_nx;
    logic [15:0]        peak_nx;

    logic               start_frame;
    logic               accum_en;
    logic               complete;
    logic               clear_frame;

    // Strobe delay line matching the CORDIC pipeline depth; frame_sync leaves it alone.
    generate
        if (LATENCY == 1) begin : g_dly_single
            always_ff @(posedge clock) begin
                if (!reset) begin
                    vdly <= '0;
                end else begin
                    vdly <= in_valid;
                end
            end
        end else begin : g_dly_multi
            always_ff @(posedge clock) begin
                if (!reset) begin
                    vdly <= '0;
                end else begin
                    vdly <= {vdly[LATENCY-2:0], in_valid};
                end
            end
        end
    endgenerate

    assign v_al  = vdly[LATENCY-1];

    // A negative CORDIC magnitude can only be rounding noise, so it counts as zero.
    assign mag_c = mag[15] ? 16'h0000 : mag;

`ifdef DOA_FRAME_AVG_THRESH_EN
    assign accept = v_al && (mag_c >= thresh);
`else
    logic unused_thresh;
    assign unused_thresh = ^thresh;
    assign accept        = v_al;
`endif

    // Angle offsets are taken relative to the frame's first angle so that the
    // sum never straddles the +/-180 degree seam when samples cluster.
    assign diff       = ang - ref_ang;
    assign ang_sum_nx = ang_sum + {{LOG2N{diff[15]}}, diff};
    assign mag_sum_nx = mag_sum + {{LOG2N{1'b0}}, mag_c};
    assign peak_nx    = (mag_c > peak) ? mag_c : peak;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode; frame_sync overrides everything except the
    // pulse already being shown, and a coincident sample opens the new frame.
    always_comb begin
        state_next  = state;
        start_frame = 1'b0;
        accum_en    = 1'b0;
        complete    = 1'b0;
        clear_frame = 1'b0;
        out_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    start_frame = 1'b1;
                    state_next  = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    accum_en = 1'b1;
                    if (count == LAST_COUNT) begin
                        complete   = 1'b1;
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (accept) begin
                    start_frame = 1'b1;
                    state_next  = ACCUM;
                end else begin
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (frame_sync) begin
            accum_en    = 1'b0;
            complete    = 1'b0;
            clear_frame = 1'b1;
            start_frame = accept;
            state_next  = accept ? ACCUM : IDLE;
        end
    end

    // Frame accumulators: a new frame seeds from the sample, otherwise accumulate or clear.
    always_ff @(posedge clock) begin
        if (!reset) begin
            ref_ang <= '0;
            ang_sum <= '0;
            mag_sum <= '0;
            peak    <= '0;
            count   <= '0;
        end else if (start_frame) begin
            ref_ang <= ang;
            ang_sum <= '0;
            mag_sum <= {{LOG2N{1'b0}}, mag_c};
            peak    <= mag_c;
            count   <= CW'(1);
        end else if (accum_en) begin
            ang_sum <= ang_sum_nx;
            mag_sum <= mag_sum_nx;
            peak    <= peak_nx;
            count   <= count + CW'(1);
        end else if (clear_frame) begin
            ang_sum <= '0;
            mag_sum <= '0;
            count   <= '0;
        end
    end

    // Results are captured from the completing sample so they are stable while out_valid is high.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mag_peak <= '0;
            mag_mean <= '0;
            ang_mean <= '0;
        end else if (complete) begin
            mag_peak <= peak_nx;
            mag_mean <= mag_sum_nx[SW-1:LOG2N];
            ang_mean <= ref_ang + ang_sum_nx[SW-1:LOG2N];
        end
    end

endmodule

// File: tb/tb_doa_frame_avg.sv
// tb_doa_frame_avg: self-checking bench for doa_frame_avg.
// Stimulus is laid out on an absolute cycle timeline; a queue-based frame
// model predicts the outputs after every clock edge.
module tb_doa_frame_avg;

    localparam int LAT   = 12;
    localparam int L2N   = 2;
    localparam int N     = 1 << L2N;
    localparam int DEPTH = 1024;

    typedef struct packed {
        logic [15:0] m;
        logic [15:0] a;
    } samp_t;

    logic        clock      = 1'b0;
    logic        reset      = 1'b0;
    logic        in_valid   = 1'b0;
    logic        frame_sync = 1'b0;
    logic [15:0] mag        = '0;
    logic [15:0] ang        = '0;
    logic [15:0] thresh     = '0;
    logic        out_valid;
    logic [15:0] mag_peak;
    logic [15:0] mag_mean;
    logic [15:0] ang_mean;

    logic        sch_v   [DEPTH];
    logic        sch_fs  [DEPTH];
    logic        sch_rst [DEPTH];
    logic [15:0] sch_m   [DEPTH];
    logic [15:0] sch_a   [DEPTH];

    int          cyc       = 0;
    int          checks    = 0;
    int          failures  = 0;
    int          last_rst  = -1;
    int          exp_pulses = 0;
    samp_t       frame_q[$];
    int          pulse_q[$];
    logic        exp_ov   = 1'b0;
    logic [15:0] exp_peak = '0;
    logic [15:0] exp_mean = '0;
    logic [15:0] exp_ang  = '0;

    doa_frame_avg #(.LATENCY(LAT), .LOG2N(L2N)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .frame_sync (frame_sync),
        .mag        (mag),
        .ang        (ang),
        .thresh     (thresh),
        .out_valid  (out_valid),
        .mag_peak   (mag_peak),
        .mag_mean   (mag_mean),
        .ang_mean   (ang_mean)
    );

    // Free-running 10 ns clock.
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    task automatic checkCount(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // A sample whose strobe enters at cycle t carries CORDIC data at t+LAT.
    task automatic addSample(input int t, input logic [15:0] m, input logic [15:0] a);
        sch_v[t]       = 1'b1;
        sch_m[t + LAT] = m;
        sch_a[t + LAT] = a;
    endtask

    // Reference behaviour at clock edge c, described as a list of accepted samples.
    task automatic modelStep(input int c);
        logic        va;
        logic [15:0] mc;
        logic        acc;
        logic [15:0] r;
        logic [15:0] dd;
        samp_t       s;
        int          sm;
        int          sd;
        int          pk;
        exp_ov = 1'b0;
        if (sch_rst[c]) begin
            last_rst = c;
            frame_q.delete();
            exp_peak = '0;
            exp_mean = '0;
            exp_ang  = '0;
            return;
        end
        va = 1'b0;
        if (c >= LAT) begin
            va = (c - LAT > last_rst) && sch_v[c - LAT];
        end
        mc = sch_m[c][15] ? 16'h0000 : sch_m[c];
`ifdef DOA_FRAME_AVG_THRESH_EN
        acc = va && (mc >= thresh);
`else
        acc = va;
`endif
        if (sch_fs[c]) frame_q.delete();
        if (acc) begin
            s.m = mc;
            s.a = sch_a[c];
            frame_q.push_back(s);
            if (frame_q.size() == N) begin
                r  = frame_q[0].a;
                sm = 0;
                sd = 0;
                pk = 0;
                foreach (frame_q[i]) begin
                    dd = frame_q[i].a - r;
                    sd += int'($signed(dd));
                    sm += int'(frame_q[i].m);
                    if (int'(frame_q[i].m) > pk) pk = int'(frame_q[i].m);
                end
                exp_peak = 16'(pk);
                exp_mean = 16'(sm / N);
                exp_ang  = r + 16'(sd >>> L2N);
                exp_ov   = 1'b1;
                exp_pulses++;
                frame_q.delete();
            end
        end
    endtask

    // Plays n cycles of the timeline, checking every output one ns after each edge.
    task automatic applyStimulus(input int n);
        for (int k = 0; k < n; k++) begin
            reset      = ~sch_rst[cyc];
            in_valid   = sch_v[cyc];
            frame_sync = sch_fs[cyc];
            mag        = sch_m[cyc];
            ang        = sch_a[cyc];
            @(posedge clock);
            modelStep(cyc);
            #1;
            if (out_valid === 1'b1) pulse_q.push_back(cyc);
            checkOutput("out_valid", {15'd0, out_valid}, {15'd0, exp_ov});
            checkOutput("mag_peak", mag_peak, exp_peak);
            checkOutput("mag_mean", mag_mean, exp_mean);
            checkOutput("ang_mean", ang_mean, exp_ang);
            cyc++;
        end
    endtask

    // Directed steps followed by a randomized stretch.
    initial begin
        int b;
        int p0;
        logic [15:0] mags3 [4];
        for (int i = 0; i < DEPTH; i++) begin
            sch_v[i]   = 1'b0;
            sch_fs[i]  = 1'b0;
            sch_rst[i] = 1'b0;
            sch_m[i]   = 16'($urandom);
            sch_a[i]   = 16'($urandom);
        end

        // Reset state.
        sch_rst[0] = 1'b1;
        sch_rst[1] = 1'b1;
        applyStimulus(4);
        checkOutput("reset_peak", mag_peak, 16'h0000);
        checkOutput("reset_valid", {15'd0, out_valid}, 16'h0000);

        // Latency alignment: only the aligned cycle carries the small magnitude.
        b  = cyc;
        p0 = pulse_q.size();
        for (int i = b; i < b + LAT + 14; i++) sch_m[i] = 16'h7FFF;
        addSample(b, 16'h0100, 16'h0000);
        for (int i = 0; i < 3; i++) addSample(b + 5 + i, 16'h0040, 16'h0000);
        applyStimulus(LAT + 12);
        checkOutput("latency_peak", mag_peak, 16'h0100);
        checkCount("latency_pulses", pulse_q.size() - p0, 1);

        // Basic frame.
        b  = cyc;
        p0 = pulse_q.size();
        for (int i = 0; i < 4; i++) addSample(b + i, 16'((i + 1) * 100), 16'h2000);
        applyStimulus(LAT + 6);
        checkOutput("basic_peak", mag_peak, 16'd400);
        checkOutput("basic_mean", mag_mean, 16'd250);
        checkOutput("basic_ang", ang_mean, 16'h2000);
        checkCount("basic_pulses", pulse_q.size() - p0, 1);
        checkCount("basic_pulse_cycle", pulse_q[$], b + 3 + LAT);

        // Wrap at 180 degrees.
        b = cyc;
        for (int i = 0; i < 4; i++) addSample(b + i, 16'd1000, (i % 2 == 0) ? 16'h7F00 : 16'h8100);
        applyStimulus(LAT + 6);
        checkOutput("wrap180_ang", ang_mean, 16'h8000);

        // Wrap at 0 degrees with negative magnitudes.
        b = cyc;
        for (int i = 0; i < 4; i++) addSample(b + i, 16'hFF00, (i % 2 == 0) ? 16'h0010 : 16'hFFF0);
        applyStimulus(LAT + 6);
        checkOutput("wrap0_ang", ang_mean, 16'h0000);
        checkOutput("wrap0_peak", mag_peak, 16'h0000);

        // Continuous valid: back-to-back frames.
        b  = cyc;
        p0 = pulse_q.size();
        for (int i = 0; i < 8; i++) addSample(b + i, 16'(50 + i), 16'(i * 16));
        applyStimulus(LAT + 10);
        checkCount("b2b_pulses", pulse_q.size() - p0, 2);
        if (pulse_q.size() - p0 == 2) checkCount("b2b_gap", pulse_q[p0 + 1] - pulse_q[p0], 4);

        // frame_sync after two samples discards them.
        b  = cyc;
        p0 = pulse_q.size();
        mags3 = '{16'd300, 16'd310, 16'd320, 16'd330};
        addSample(b, 16'd900, 16'h1234);
        addSample(b + 1, 16'd900, 16'h1234);
        sch_fs[b + 2 + LAT] = 1'b1;
        for (int i = 0; i < 4; i++) addSample(b + 3 + i, mags3[i], 16'h1234);
        applyStimulus(LAT + 10);
        checkCount("fsync_pulses", pulse_q.size() - p0, 1);
        checkCount("fsync_pulse_cycle", pulse_q[$], b + 6 + LAT);
        checkOutput("fsync_peak", mag_peak, 16'd330);

        // Reset mid-frame loses the partial frame and pending strobes.
        b  = cyc;
        p0 = pulse_q.size();
        for (int i = 0; i < 5; i++) addSample(b + i, 16'd500, 16'h0100);
        sch_rst[b + LAT + 1] = 1'b1;
        applyStimulus(LAT + 8);
        checkCount("midreset_pulses", pulse_q.size() - p0, 0);
        checkOutput("midreset_peak", mag_peak, 16'h0000);
        checkOutput("midreset_mean", mag_mean, 16'h0000);
        checkOutput("midreset_ang", ang_mean, 16'h0000);

        // Threshold gate (or plain acceptance when the gate is compiled out).
        b      = cyc;
        p0     = pulse_q.size();
        thresh = 16'd50;
        mags3  = '{16'd10, 16'd60, 16'd70, 16'd20};
        for (int i = 0; i < 4; i++) addSample(b + i, mags3[i], 16'h0400);
        addSample(b + 4, 16'd80, 16'h0400);
        addSample(b + 5, 16'd90, 16'h0400);
        applyStimulus(LAT + 8);
        checkCount("thresh_pulses", pulse_q.size() - p0, 1);
`ifdef DOA_FRAME_AVG_THRESH_EN
        checkCount("thresh_pulse_cycle", pulse_q[$], b + 5 + LAT);
        checkOutput("thresh_mean", mag_mean, 16'd75);
`else
        checkCount("thresh_pulse_cycle", pulse_q[$], b + 3 + LAT);
        checkOutput("thresh_mean", mag_mean, 16'd40);
`endif

        // Randomized traffic with occasional frame_sync and one reset.
        b      = cyc;
        thresh = 16'($urandom_range(0, 1500));
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                addSample(b + i,
                          ($urandom_range(0, 7) == 0) ? (16'hF000 | 16'($urandom_range(0, 4095)))
                                                      : 16'($urandom_range(0, 4000)),
                          16'($urandom));
            end
            sch_fs[b + i] = ($urandom_range(0, 24) == 0);
        end
        sch_rst[b + 150] = 1'b1;
        p0 = pulse_q.size();
        begin
            int e0;
            e0 = exp_pulses;
            applyStimulus(300 + LAT + 4);
            checkCount("random_pulses", pulse_q.size() - p0, exp_pulses - e0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/doa_frame_avg.md
# doa_frame_avg

Frame averager that sits directly downstream of the vectoring-mode CORDIC. It delays the sample-valid strobe by the CORDIC pipeline latency so that the strobe lines up with the CORDIC's magnitude (`xo`) and angle (`zo`) outputs. It then accumulates 2^LOG2N accepted samples and reports, once per frame, the peak magnitude, the mean magnitude and a wrap-safe mean angle. This is the direction-of-arrival estimate for one acoustic vector sensor channel pair.

## Interface
- `LATENCY`, default 12: CORDIC pipeline depth in cycles; must equal the CORDIC `stages` value. Range 1..32.
- `LOG2N`, default 4: log2 of frame length in accepted samples. Range 1..8.
- `clock`  in  1: rising-edge clock.
- `reset`  in  1: synchronous, active-low reset.
- `in_valid`  in  1: high in the cycle a sample enters the CORDIC inputs.
- `frame_sync`  in  1: discards the partial frame and restarts accumulation.
- `mag`  in  16: CORDIC `xo`, signed, valid LATENCY cycles after `in_valid`.
- `ang`  in  16: CORDIC `zo`, signed; 2^16 counts = 360°, 0x4000 = 90°.
- `thresh`  in  16: unsigned minimum magnitude. Only used with `DOA_FRAME_AVG_THRESH_EN`.
- `out_valid`  out  1: one-cycle pulse when a frame completes.
- `mag_peak`  out  16: maximum clamped magnitude in the frame.
- `mag_mean`  out  16: mean clamped magnitude.
- `ang_mean`  out  16: circular mean angle.

## Operation
- **Valid delay line:** LATENCY-deep shift register on `in_valid`. The tap output `v_al` qualifies `mag` and `ang` in the same cycle.
- **Magnitude clamp:** `mag` is interpreted as signed; negative values are clamped to 0 before any use.
- **Accept condition:** `v_al`, plus (clamped `mag` >= `thresh`) when `DOA_FRAME_AVG_THRESH_EN` is defined.
- **State IDLE:** on an accepted sample:
  - `ref` <= `ang`
  - angle sum <= 0
  - magnitude sum <= `mag`
  - peak <= `mag`
  - count <= 1
  - go to ACCUM.
- **State ACCUM:** on an accepted sample:
  - `d` = (`ang` − `ref`) taken modulo 2^16 and interpreted as signed 16-bit.
  - Angle sum (signed, 16+LOG2N bits) += `d`.
  - Magnitude sum (unsigned, 16+LOG2N bits) += `mag`.
  - Peak = max(peak, `mag`).
  - count += 1.
- **Frame completion:** when the accepted sample brings count to 2^LOG2N, go to DONE in the next cycle.
- **State DONE (one cycle):**
  - `mag_mean` <= magnitude sum >> LOG2N.
  - `ang_mean` <= `ref` + (angle sum >>> LOG2N), truncated to 16 bits, wrapping.
  - `mag_peak` <= peak.
  - `out_valid` = 1.
  - Next state is IDLE.
  - An accepted sample arriving in the DONE cycle is treated as the first sample of the next frame, so no sample is lost.
- **Result hold:** `mag_peak`, `mag_mean` and `ang_mean` hold their values until the next DONE.
- **`frame_sync`:**
  - In any state it forces IDLE and clears count and the sums.
  - It has priority over the DONE update: a frame completing in the same cycle produces no `out_valid`.
  - If an accepted sample coincides with `frame_sync`, that sample starts the new frame (count = 1).
  - The delay line is not cleared.
- **Angle limit:** the circular mean is exact only when all samples in a frame lie within ±180° of `ref`. This is the intended use.

## Timing
- **Reset:** while `reset` = 0 at a rising edge:
  - delay line, count and sums cleared
  - state = IDLE
  - `out_valid` = 0
  - `mag_peak`, `mag_mean` and `ang_mean` = 0x0000.
- **Reset mid-frame:** the partial frame is discarded. Pending delayed valids are lost.
- **`in_valid` to `v_al`:** exactly LATENCY cycles.
- **Frame latency:** last accepted sample at edge k → `out_valid` high during cycle k+1, results stable from k+1.
- **Throughput:** one sample per cycle; back-to-back frames are sustained with no gap.

## Configuration
- `DOA_FRAME_AVG_THRESH_EN`:
  - Defined: samples with clamped `mag` < `thresh` are ignored (no count, no accumulation). A frame then completes after 2^LOG2N samples at or above threshold.
  - Undefined: `thresh` is unused and every `v_al` sample is accepted.

## Test plan
- **Latency alignment:** LATENCY=12, single `in_valid` at cycle 0, `mag` driven to 0x0100 only at cycle 12 and 0x7FFF at all other cycles. After the frame completes, `mag_peak` = 0x0100.
- **Basic frame:** LOG2N=2, magnitudes 100, 200, 300, 400 and angles all 0x2000 → one `out_valid` pulse; `mag_peak` = 400, `mag_mean` = 250, `ang_mean` = 0x2000.
- **Wrap at 180°:** angles 0x7F00, 0x8100, 0x7F00, 0x8100 → `ang_mean` = 0x8000 (not 0x0000).
- **Wrap at 0°:** angles 0x0010, 0xFFF0, 0x0010, 0xFFF0 → `ang_mean` = 0x0000. Negative `mag` 0xFF00 inputs give `mag_peak` = 0.
- **Frame control:** continuous valid for 8 cycles with LOG2N=2 → two pulses exactly 4 cycles apart. Then `frame_sync` after 2 samples → no pulse until 4 further samples. `reset` asserted mid-frame → all outputs 0 and no pulse.
- **Threshold (macro defined):** `thresh` = 50, magnitudes 10, 60, 70, 20, 80, 90 → completion after the 90 sample; `mag_mean` = 75. With the macro undefined, completion occurs after the 20 sample.
